div_seq_32: RTL and testbench

Multi-cycle RV32M divide sequencer in the EX stage. Accepts a DIV/DIVU/REM/REMU request from decode/issue with operands, runs a radix-2 restoring division over 32 iterations, applies RISC-V sign and special-case rules, and delivers one result to the EX/MEM register. While it works, it drives a stall to the hazard unit.

---
 rtl/div_seq_32_pkg.sv | 43 ++++
 rtl/div_seq_32_if.sv | 24 ++
 rtl/div_seq_32_step.sv | 29 ++
 rtl/div_seq_32.sv | 156 +++++++++++++++
 tb/tb_div_seq_32.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/div_seq_32_pkg.sv
// Shared definitions for the RV32M divide sequencer.
// Op encodings, FSM states and the two special-case constants.
`ifndef GPR_WIDTH
`define GPR_WIDTH 32
`endif
`ifndef On
`define On 1'b1
`endif
`ifndef Off
`define Off 1'b0
`endif

package div_seq_32_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } div_state_t;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // op_i[0]=1 selects the unsigned flavour
  function automatic logic op_signed(logic [1:0] op);
    return ~op[0];
  endfunction

  // op_i[1]=1 selects the remainder
  function automatic logic op_rem(logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_seq_32_if.sv
// Issue/result bundle between decode, the divider and EX/MEM.
// The divider sits on the slave side.
interface div_seq_32_if #(
  parameter int WIDTH = `GPR_WIDTH
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] rs1_i;
  logic [WIDTH-1:0] rs2_i;
  logic             flush_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, flush_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/div_seq_32_step.sv
// One radix-2 restoring step on the {R,Q} pair.
// Trial subtract of the divisor from {R,Q[msb]}.
module div_step #(
  parameter int WIDTH = `GPR_WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH+1:0] diff;
  logic             ge;

  // Trial subtraction; keep it if non-negative, otherwise restore
  always_comb begin
    diff = {r, q[WIDTH-1]} - {2'b00, d};
    ge   = ~diff[WIDTH+1];
    if (ge) begin
      r_nxt = diff[WIDTH:0];
      q_nxt = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_nxt = {r[WIDTH-1:0], q[WIDTH-1]};
      q_nxt = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq_32.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer for the EX stage.
// Stalls the pipe via busy while a divide is in flight.
module div_seq_32
  import div_seq_32_pkg::*;
#(
  parameter int WIDTH = `GPR_WIDTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  div_seq_32_if.slave bus
);

  div_state_t       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] d_r;
  logic             qneg;
  logic             rneg;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] result_r;
  logic             done_r;

  logic             idle_or_done;
  logic             accept;
  logic             is_signed;
  logic             is_rem;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div0;
  logic             ovf;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH-1:0] fix_res;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r     (r_r),
    .q     (q_r),
    .d     (d_r),
    .r_nxt (r_nxt),
    .q_nxt (q_nxt)
  );

  // Acceptance and the combinational stall request
  always_comb begin
    idle_or_done = (state == S_IDLE) || (state == S_DONE);
    accept       = idle_or_done && bus.start_i && !bus.flush_i;
    bus.busy_o   = accept
                || (state == S_PREP)
                || (state == S_ITER)
                || (state == S_FIX);
  end

  // Operand magnitudes, special cases and final sign fix-up
  always_comb begin
    is_signed = op_signed(op_q);
    is_rem    = op_rem(op_q);
    a_neg     = is_signed && a_q[WIDTH-1];
    b_neg     = is_signed && b_q[WIDTH-1];
    a_mag     = a_neg ? (~a_q + 1'b1) : a_q;
    b_mag     = b_neg ? (~b_q + 1'b1) : b_q;
    div0      = (b_q == '0);
    ovf       = is_signed && (a_q == INT_MIN) && (b_q == ALL_ONES);
    if (div0)
      special_res = is_rem ? a_q : ALL_ONES;
    else
      special_res = is_rem ? '0 : INT_MIN;
    if (is_rem)
      fix_res = rneg ? (~r_r[WIDTH-1:0] + 1'b1) : r_r[WIDTH-1:0];
    else
      fix_res = qneg ? (~q_r + 1'b1) : q_r;
  end

  // Sequencer FSM with registered result and done pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_r      <= '0;
      q_r      <= '0;
      d_r      <= '0;
      qneg     <= `Off;
      rneg     <= `Off;
      cnt      <= '0;
      result_r <= '0;
      done_r   <= `Off;
    end else if (bus.flush_i) begin
      state  <= S_IDLE;
      done_r <= `Off;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            op_q  <= bus.op_i;
            a_q   <= bus.rs1_i;
            b_q   <= bus.rs2_i;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          if (div0 || ovf) begin
            result_r <= special_res;
            done_r   <= `On;
            state    <= S_DONE;
          end else begin
            r_r   <= '0;
            q_r   <= a_mag;
            d_r   <= b_mag;
            qneg  <= a_neg ^ b_neg;
            rneg  <= a_neg;
            cnt   <= '0;
            state <= S_ITER;
          end
        end
        S_ITER: begin
          r_r <= r_nxt;
          q_r <= q_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31)
            state <= S_FIX;
        end
        S_FIX: begin
          result_r <= fix_res;
          done_r   <= `On;
          state    <= S_DONE;
        end
        S_DONE: begin
          done_r <= `Off;
          if (bus.start_i) begin
            op_q  <= bus.op_i;
            a_q   <= bus.rs1_i;
            b_q   <= bus.rs2_i;
            state <= S_PREP;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          done_r <= `Off;
        end
      endcase
    end
  end

  assign bus.done_o   = done_r;
  assign bus.result_o = result_r;

endmodule

// File: tb/tb_div_seq_32.sv
// Scoreboarded bench for div_seq_32.
// Directed vectors; monitor checks value and cycle of each done pulse.
module tb_div_seq_32;

  logic clk;
  logic rst;
  int unsigned cyc;
  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic [31:0] res;
    int unsigned at;
  } exp_t;

  exp_t sb[$];

  div_seq_32_if #(.WIDTH(32)) bus ();

  div_seq_32 #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, want %h", name, act, req);
  endtask

  // Monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.done_o === 1'b1) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_done: got result %h at cycle %0d, want no done",
                 bus.result_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.result_o, e.res);
        check("done_cycle", cyc, e.at);
      end
    end
  end

  // Present a request in the current cycle (caller is at a negedge)
  task automatic drive(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                       logic [31:0] exp, int lat, bit push);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    if (push) sb.push_back('{res: exp, at: cyc + lat});
    #1;
    check("busy_accept", {31'b0, bus.busy_o}, 32'd1);
  endtask

  // Drop start and scramble operands to prove they were latched
  task automatic release_inputs();
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.op_i    = 2'b10;
    bus.rs1_i   = 32'hDEAD_BEEF;
    bus.rs2_i   = 32'h0000_0003;
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total_cnt++;
      $display("FAIL timeout: got %0d pending results, want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                     logic [31:0] exp, int lat);
    @(negedge clk);
    drive(op, a, b, exp, lat, 1'b1);
    release_inputs();
    drain(60);
  endtask

  int unsigned t0;

  initial begin
    cyc = 0;
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i = 2'b00;
    bus.rs1_i = '0;
    bus.rs2_i = '0;
    bus.flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy_o}, 32'd0);
    check("rst_done", {31'b0, bus.done_o}, 32'd0);
    check("rst_result", bus.result_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // DIVU 100/7 with a busy trace over cycles 1..35
    @(negedge clk);
    drive(2'b01, 32'd100, 32'd7, 32'd14, 35, 1'b1);
    for (int i = 1; i <= 35; i++) begin
      if (i == 1) release_inputs();
      else @(negedge clk);
      check($sformatf("busy_c%0d", i), {31'b0, bus.busy_o},
            (i < 35) ? 32'd1 : 32'd0);
    end
    drain(10);

    run(2'b11, 32'd100, 32'd7, 32'd2, 35);
    run(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
    run(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
    run(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 35);
    run(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    run(2'b11, 32'd5, 32'd0, 32'd5, 2);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

    // Flush in cycle 10 of an op: no done, back to idle
    @(negedge clk);
    drive(2'b01, 32'd100, 32'd7, 32'd0, 35, 1'b0);
    release_inputs();
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_busy", {31'b0, bus.busy_o}, 32'd0);
    check("flush_done", {31'b0, bus.done_o}, 32'd0);
    repeat (40) @(negedge clk);
    run(2'b01, 32'd9, 32'd3, 32'd3, 35);

    // Back-to-back: new start in the DONE cycle
    @(negedge clk);
    t0 = cyc;
    drive(2'b01, 32'd9, 32'd3, 32'd3, 35, 1'b1);
    release_inputs();
    while (cyc < t0 + 35) @(negedge clk);
    drive(2'b11, 32'd10, 32'd4, 32'd2, 35, 1'b1);
    release_inputs();
    drain(60);

    // Reset in the middle of ITER
    @(negedge clk);
    drive(2'b00, 32'd1000, 32'd7, 32'd0, 35, 1'b0);
    release_inputs();
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", {31'b0, bus.busy_o}, 32'd0);
    check("mid_rst_done", {31'b0, bus.done_o}, 32'd0);
    check("mid_rst_result", bus.result_o, 32'd0);
    repeat (40) @(negedge clk);

    run(2'b00, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 35);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t, want finish earlier", $time);
    $fatal(1);
  end

endmodule
